// File: rtl/inst_prefetch_if.sv
// Fetch-side bus of the instruction prefetcher: ROM port, redirect request and
// the core-facing instruction handshake.
interface inst_prefetch_if;
    logic [31:0] rom_addr_o;
    logic        rom_ce_o;
    logic [31:0] rom_data_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        ready_i;
    logic        valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;

    modport master (
        output rom_addr_o, rom_ce_o, valid_o, inst_o, pc_o,
        input  rom_data_i, branch_flag_i, branch_target_i, ready_i
    );

    modport slave (
        input  rom_addr_o, rom_ce_o, valid_o, inst_o, pc_o,
        output rom_data_i, branch_flag_i, branch_target_i, ready_i
    );
endinterface

// File: rtl/inst_prefetch.sv
// Instruction prefetcher: fetches sequentially from a combinational ROM into a
// DEPTH-entry {pc, inst} FIFO; a branch flushes the FIFO and redirects fetch.
module inst_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic            clk,
    input logic            rst,
    inst_prefetch_if.master bus
);
    localparam int unsigned PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic [31:0]   fifo_pc_q   [DEPTH];
    logic [31:0]   fifo_inst_q [DEPTH];
    logic          push, pop, empty;
    logic          unused_tgt_lsb;

    assign unused_tgt_lsb = ^bus.branch_target_i[1:0];

    assign empty = (cnt_q == '0);
    assign push  = rst & (cnt_q < FULL) & ~bus.branch_flag_i;
    assign pop   = bus.valid_o & bus.ready_i;

    // Outputs are gated by rst so they read as idle even before the reset edge.
    assign bus.rom_ce_o   = push;
    assign bus.rom_addr_o = rst ? pc_q : RESET_PC;
    assign bus.valid_o    = rst & ~empty & ~bus.branch_flag_i;
    assign bus.inst_o     = (rst & ~empty) ? fifo_inst_q[rd_q] : '0;
    assign bus.pc_o       = (rst & ~empty) ? fifo_pc_q[rd_q]   : '0;

    always_comb begin
        pc_d  = pc_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (bus.branch_flag_i) begin
            pc_d  = {bus.branch_target_i[31:2], 2'b00};
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                pc_d = pc_q + 32'd4;
                wr_d = wr_q + 1'b1;
            end
            if (pop) begin
                rd_d = rd_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q  <= RESET_PC;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_q]   <= pc_q;
            fifo_inst_q[wr_q] <= bus.rom_data_i;
        end
    end
endmodule

// File: tb/tb_inst_prefetch.sv
// Self-checking bench for inst_prefetch: directed scenarios plus randomized
// traffic compared against a queue-based model of the prefetcher.
module tb_inst_prefetch;
    localparam int unsigned TB_DEPTH    = 4;
    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] rom_xor;
    int          checks;
    int          failures;

    // Model: queue of {pc, inst} plus the fetch address.
    logic [63:0] mq[$];
    logic [31:0] m_pc;

    inst_prefetch_if bus();

    inst_prefetch #(.DEPTH(TB_DEPTH), .RESET_PC(TB_RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    assign bus.rom_data_i = bus.rom_addr_o ^ rom_xor;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic e_ce();
        return rst && (mq.size() < TB_DEPTH) && !bus.branch_flag_i;
    endfunction

    function automatic logic e_valid();
        return rst && (mq.size() != 0) && !bus.branch_flag_i;
    endfunction

    function automatic logic [31:0] e_addr();
        return rst ? m_pc : TB_RESET_PC;
    endfunction

    function automatic logic [31:0] e_pc();
        logic [63:0] h;
        if (!rst || mq.size() == 0) return 32'h0;
        h = mq[0];
        return h[63:32];
    endfunction

    function automatic logic [31:0] e_inst();
        logic [63:0] h;
        if (!rst || mq.size() == 0) return 32'h0;
        h = mq[0];
        return h[31:0];
    endfunction

    task automatic model_update();
        logic do_pop, do_push;
        if (!rst) begin
            mq.delete();
            m_pc = TB_RESET_PC;
        end else if (bus.branch_flag_i) begin
            mq.delete();
            m_pc = bus.branch_target_i & 32'hFFFF_FFFC;
        end else begin
            do_pop  = e_valid() && bus.ready_i;
            do_push = e_ce();
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back({m_pc, m_pc ^ rom_xor});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.branch_flag_i = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.branch_flag_i = 1'b1;
        bus.ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.branch_target_i = $urandom;
            @(negedge clk);
            checks++;
            if (bus.rom_ce_o !== 1'b0 || bus.valid_o !== 1'b0) begin
                failures++;
                $display("FAIL reset_ctrl ce=%b valid=%b required ce=0 valid=0", bus.rom_ce_o, bus.valid_o);
            end
            checks++;
            if (bus.rom_addr_o !== TB_RESET_PC || bus.pc_o !== 32'h0 || bus.inst_o !== 32'h0) begin
                failures++;
                $display("FAIL reset_data addr=%h pc=%h inst=%h required %h/0/0",
                         bus.rom_addr_o, bus.pc_o, bus.inst_o, TB_RESET_PC);
            end
            tick();
        end
        bus.branch_flag_i = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_stream();
        rom_xor = 32'h0;
        do_reset();
        bus.ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (bus.rom_addr_o !== 32'(4 * i) || bus.rom_ce_o !== 1'b1) begin
                failures++;
                $display("FAIL stream_fetch cyc=%0d addr=%h ce=%b required addr=%h ce=1",
                         i, bus.rom_addr_o, bus.rom_ce_o, 32'(4 * i));
            end
            checks++;
            if (bus.valid_o !== (i > 0)) begin
                failures++;
                $display("FAIL stream_valid cyc=%0d valid=%b required %b", i, bus.valid_o, (i > 0));
            end
            if (i > 0) begin
                checks++;
                if (bus.pc_o !== 32'(4 * (i - 1)) || bus.inst_o !== 32'(4 * (i - 1))) begin
                    failures++;
                    $display("FAIL stream_head cyc=%0d pc=%h inst=%h required %h",
                             i, bus.pc_o, bus.inst_o, 32'(4 * (i - 1)));
                end
            end
            tick();
        end
    endtask

    task automatic test_full_stall();
        rom_xor = 32'h0;
        do_reset();
        bus.ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (bus.rom_ce_o !== (i < 4) || bus.rom_addr_o !== ((i < 4) ? 32'(4 * i) : 32'd16)) begin
                failures++;
                $display("FAIL stall_fetch cyc=%0d ce=%b addr=%h required ce=%b addr=%h", i,
                         bus.rom_ce_o, bus.rom_addr_o, (i < 4), ((i < 4) ? 32'(4 * i) : 32'd16));
            end
            checks++;
            if (bus.pc_o !== 32'h0 || bus.valid_o !== (i > 0)) begin
                failures++;
                $display("FAIL stall_head cyc=%0d pc=%h valid=%b required pc=0 valid=%b",
                         i, bus.pc_o, bus.valid_o, (i > 0));
            end
            tick();
        end
    endtask

    task automatic test_refill();
        bus.ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.rom_ce_o !== 1'b0 || bus.valid_o !== 1'b1 || bus.pc_o !== 32'h0) begin
            failures++;
            $display("FAIL refill_pop ce=%b valid=%b pc=%h required ce=0 valid=1 pc=0",
                     bus.rom_ce_o, bus.valid_o, bus.pc_o);
        end
        tick();
        bus.ready_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.pc_o !== 32'h4 || bus.rom_ce_o !== 1'b1 || bus.rom_addr_o !== 32'd16) begin
            failures++;
            $display("FAIL refill_next pc=%h ce=%b addr=%h required pc=4 ce=1 addr=10",
                     bus.pc_o, bus.rom_ce_o, bus.rom_addr_o);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.rom_ce_o !== 1'b0 || bus.rom_addr_o !== 32'd20) begin
            failures++;
            $display("FAIL refill_full ce=%b addr=%h required ce=0 addr=14", bus.rom_ce_o, bus.rom_addr_o);
        end
        tick();
    endtask

    task automatic test_branch();
        rom_xor = 32'h0;
        do_reset();
        bus.ready_i = 1'b0;
        repeat (3) tick();
        bus.branch_flag_i = 1'b1;
        bus.branch_target_i = 32'h0000_0103;
        @(negedge clk);
        checks++;
        if (bus.valid_o !== 1'b0 || bus.rom_ce_o !== 1'b0) begin
            failures++;
            $display("FAIL branch_cycle valid=%b ce=%b required 0/0", bus.valid_o, bus.rom_ce_o);
        end
        tick();
        bus.branch_flag_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rom_addr_o !== 32'h100 || bus.valid_o !== 1'b0 || bus.rom_ce_o !== 1'b1) begin
            failures++;
            $display("FAIL branch_redirect addr=%h valid=%b ce=%b required 100/0/1",
                     bus.rom_addr_o, bus.valid_o, bus.rom_ce_o);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h100 || bus.inst_o !== 32'h100) begin
            failures++;
            $display("FAIL branch_head valid=%b pc=%h inst=%h required 1/100/100",
                     bus.valid_o, bus.pc_o, bus.inst_o);
        end
        tick();
        // Back-to-back redirects: the last target wins.
        bus.branch_flag_i = 1'b1;
        bus.branch_target_i = 32'h0000_2000;
        tick();
        bus.branch_target_i = 32'h0000_3006;
        tick();
        bus.branch_flag_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rom_addr_o !== 32'h3004 || bus.rom_ce_o !== 1'b1 || bus.valid_o !== 1'b0) begin
            failures++;
            $display("FAIL branch_last addr=%h ce=%b valid=%b required 3004/1/0",
                     bus.rom_addr_o, bus.rom_ce_o, bus.valid_o);
        end
        tick();
    endtask

    task automatic test_reset_midop();
        rom_xor = 32'h1111_0000;
        do_reset();
        bus.ready_i = 1'b0;
        repeat (5) tick();
        rst = 1'b0;
        bus.branch_flag_i = 1'b1;
        bus.branch_target_i = 32'h0000_0800;
        @(negedge clk);
        checks++;
        if (bus.valid_o !== 1'b0 || bus.rom_ce_o !== 1'b0 || bus.rom_addr_o !== TB_RESET_PC || bus.inst_o !== 32'h0) begin
            failures++;
            $display("FAIL midreset_hold valid=%b ce=%b addr=%h inst=%h required 0/0/%h/0",
                     bus.valid_o, bus.rom_ce_o, bus.rom_addr_o, bus.inst_o, TB_RESET_PC);
        end
        tick();
        rst = 1'b1;
        bus.branch_flag_i = 1'b0;
        bus.ready_i = 1'b1;
        rom_xor = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.valid_o !== (i > 0) || bus.rom_addr_o !== 32'(4 * i)) begin
                failures++;
                $display("FAIL midreset_fetch cyc=%0d valid=%b addr=%h required %b/%h",
                         i, bus.valid_o, bus.rom_addr_o, (i > 0), 32'(4 * i));
            end
            if (i > 0) begin
                checks++;
                if (bus.inst_o !== bus.pc_o || bus.pc_o !== 32'(4 * (i - 1))) begin
                    failures++;
                    $display("FAIL midreset_stale cyc=%0d pc=%h inst=%h required %h/%h",
                             i, bus.pc_o, bus.inst_o, 32'(4 * (i - 1)), 32'(4 * (i - 1)));
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        rom_xor = $urandom;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 49) != 0);
            bus.branch_flag_i = ($urandom_range(0, 9) == 0);
            bus.branch_target_i = $urandom;
            bus.ready_i = ($urandom_range(0, 99) < ((i < 300) ? 30 : 70));
            @(negedge clk);
            checks++;
            if (bus.rom_ce_o !== e_ce() || bus.rom_addr_o !== e_addr()) begin
                failures++;
                $display("FAIL rand_fetch cyc=%0d ce=%b addr=%h required ce=%b addr=%h",
                         i, bus.rom_ce_o, bus.rom_addr_o, e_ce(), e_addr());
            end
            checks++;
            if (bus.valid_o !== e_valid() || bus.pc_o !== e_pc() || bus.inst_o !== e_inst()) begin
                failures++;
                $display("FAIL rand_head cyc=%0d valid=%b pc=%h inst=%h required %b/%h/%h",
                         i, bus.valid_o, bus.pc_o, bus.inst_o, e_valid(), e_pc(), e_inst());
            end
            tick();
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rom_xor = 32'h0;
        rst = 1'b0;
        bus.branch_flag_i = 1'b0;
        bus.branch_target_i = 32'h0;
        bus.ready_i = 1'b0;
        m_pc = TB_RESET_PC;
        #1;
        test_reset();
        test_stream();
        test_full_stall();
        test_refill();
        test_branch();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/inst_prefetch.md
INST_PREFETCH -- requirements
Module: inst_prefetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low (0 = reset).
REQ-005 SHALL have port rom_addr_o  output  32  the instruction ROM address.
REQ-006 SHALL have port rom_ce_o  output  1  the ROM chip enable; 1 = fetch this cycle.
REQ-007 SHALL have port rom_data_i  input  32  the ROM instruction word, combinationally valid in the same cycle as rom_addr_o/rom_ce_o.
REQ-008 SHALL have port branch_flag_i  input  1  the redirect request from the core.
REQ-009 SHALL have port branch_target_i  input  32  the redirect target address.
REQ-010 SHALL have port ready_i  input  1  the core accepts the head instruction this cycle.
REQ-011 SHALL have port valid_o  output  1  inst_o/pc_o hold a valid instruction.
REQ-012 SHALL have port inst_o  output  32  the head instruction word.
REQ-013 SHALL have port pc_o  output  32  the address of the head instruction.

Function
REQ-014 SHALL keep a fetch PC register, a DEPTH-entry FIFO of {pc, inst} pairs, read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH, and an occupancy count of log2(DEPTH)+1 bits.
REQ-015 SHALL drive rom_addr_o = fetch PC at all times.
REQ-016 SHALL drive rom_ce_o = 1 only when rst=1, count < DEPTH and branch_flag_i=0.
REQ-017 SHALL push {fetch PC, rom_data_i} at the write pointer and advance the fetch PC by 4 (32-bit wrap) in every cycle with rom_ce_o=1.
REQ-018 SHALL drive valid_o = (count != 0) & ~branch_flag_i, and inst_o/pc_o from the entry at the read pointer.
REQ-019 SHALL pop the head entry in every cycle with valid_o=1 and ready_i=1.
REQ-020 SHALL decrement count on pop only, increment on push only, and leave count unchanged on a simultaneous push and pop.
REQ-021 SHALL hold inst_o/pc_o/valid_o stable while valid_o=1 and ready_i=0, with no push beyond DEPTH entries.
REQ-022 SHALL, when count = DEPTH, deassert rom_ce_o and hold the fetch PC; a pop in that cycle re-enables fetch in the next cycle, not the same cycle.
REQ-023 SHALL, when branch_flag_i=1, discard the whole FIFO (count, read and write pointers to 0) and load the fetch PC with {branch_target_i[31:2], 2'b00} at the clock edge; no push and no pop occur in that cycle.
REQ-024 SHALL give one-cycle latency: an instruction fetched in cycle N appears on valid_o/inst_o in cycle N+1 at the earliest.
REQ-025 SHALL, on consecutive branch_flag_i cycles, take the last target; fetch resumes in the first cycle with branch_flag_i=0.
REQ-026 SHALL drive inst_o = 32'h0 and pc_o = 32'h0 whenever count = 0.

Reset
REQ-027 SHALL, while rst=0 at a clock edge, set fetch PC = RESET_PC, count = 0 and both pointers = 0, regardless of branch_flag_i or ready_i.
REQ-028 SHALL drive rom_ce_o=0, valid_o=0, inst_o=0, pc_o=0 and rom_addr_o=RESET_PC during reset.
REQ-029 SHALL, when reset is asserted mid-operation, drop all buffered entries; the first fetch after release is at RESET_PC.

Verification
REQ-030 SHALL pass this scenario: release reset, ready_i=1, ROM word = address -> rom_addr_o 0,4,8,... on consecutive cycles; valid_o rises one cycle after release; pc_o/inst_o = 0, 4, 8 on successive cycles.
REQ-031 SHALL pass this scenario: ready_i=0 from reset -> exactly 4 pushes (pc 0..12); rom_ce_o=0 from the 5th cycle on with rom_addr_o=16; pc_o stays 0.
REQ-032 SHALL pass this scenario: full FIFO, ready_i=1 for one cycle -> pc_o advances to 4; rom_ce_o=1 with addr 16 on the following cycle.
REQ-033 SHALL pass this scenario: 3 entries buffered, branch_flag_i=1 with target 32'h0000_0103 -> valid_o=0 that cycle; next cycle rom_addr_o=32'h100, count 0; the following cycle pc_o=32'h100.
REQ-034 SHALL pass this scenario: rst=0 for one cycle while FIFO is full and branch_flag_i=1 -> count 0 and rom_addr_o=RESET_PC afterwards; no stale entry ever appears on valid_o.
